// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory bus initiator.
package mem_bus_pkg;

    // Initiator FSM states; cmd_ready is asserted only in IDLE.
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA,
        RSP
    } mem_bus_state_e;

    // Data returned for a read that targets a word outside the memory.
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    // Number of words in the registered memory behind the bus.
    localparam int DEFAULT_DEPTH = 16;

    // Cycles from command accept to rsp_valid for a read.
    localparam int RD_LAT = 2;

endpackage

// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator: hardware bus master for the single-cycle addr/wr/wrdata/rddata
// memory bus. Commands arrive on a valid/ready port. Read data leaves on a
// valid/ready response port.
// Optional feature: define MEM_BUS_ADDR_CHECK_EN to reject commands whose
// address is >= DEPTH. Such commands never reach the bus. Reads of this kind
// return ERR_DATA with rsp_err set.
module mem_bus_initiator
    import mem_bus_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wrdata,
    output logic          wr,
    input  logic [DW-1:0] rddata
);

    mem_bus_state_e state;
    logic           cmd_oor;
    logic           rd_err;

    // Only one command is in flight at a time, so the port opens only when idle.
    assign cmd_ready = (state == IDLE);

`ifdef MEM_BUS_ADDR_CHECK_EN
    assign cmd_oor = (cmd_addr >= AW'(DEPTH));
`else
    assign cmd_oor = 1'b0;
`endif

    // Command FSM: registered bus outputs, the read pipeline and the response holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            wrdata    <= '0;
            wr        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rd_err    <= 1'b0;
        end else begin
            wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rd_err <= cmd_oor;
                        if (cmd_wr) begin
                            state <= WRITE;
                            if (!cmd_oor) begin
                                addr   <= cmd_addr;
                                wrdata <= cmd_wdata;
                                wr     <= 1'b1;
                            end
                        end else begin
                            state <= RD_ADDR;
                            if (!cmd_oor) begin
                                addr <= cmd_addr;
                            end
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    rsp_rdata <= rd_err ? DW'(ERR_DATA) : rddata;
                    rsp_err   <= rd_err;
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb_mem_bus_initiator: directed testbench for mem_bus_initiator with a
// behavioural model of the registered 16-word memory on the bus.
module tb_mem_bus_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic        wr;
    logic [31:0] rddata;

    logic [31:0] mem [16];

    int checkCount = 0;
    int errorCount = 0;

    mem_bus_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .addr      (addr),
        .wrdata    (wrdata),
        .wr        (wr),
        .rddata    (rddata)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered memory: samples addr/wr every edge and returns read data one cycle later.
    always @(posedge clk) begin
        if (wr) mem[addr[3:0]] <= wrdata;
        rddata <= mem[addr[3:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns one step after the edge that accepted it.
    task automatic applyStimulus(input logic isWrite, input logic [31:0] a, input logic [31:0] d, input string tag);
        int waitCycles = 0;
        cmd_wr    = isWrite;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic writeWord(input logic [31:0] a, input logic [31:0] d, input string tag);
        applyStimulus(1'b1, a, d, tag);
        checkOutput({tag, "_wr_hi"}, 32'(wr), 32'd1);
        checkOutput({tag, "_addr"}, addr, a);
        checkOutput({tag, "_wrdata"}, wrdata, d);
        tick();
        checkOutput({tag, "_wr_lo"}, 32'(wr), 32'd0);
        checkOutput({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic readWord(input logic [31:0] a, input logic [31:0] expData, input logic expErr,
                            input int holdCycles, input string tag);
        int lat = 0;
        applyStimulus(1'b0, a, 32'd0, tag);
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd2);
        checkOutput({tag, "_rdata"}, rsp_rdata, expData);
        checkOutput({tag, "_err"}, 32'(rsp_err), 32'(expErr));
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            checkOutput({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            checkOutput({tag, "_hold_rdata"}, rsp_rdata, expData);
            checkOutput({tag, "_hold_ready"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_ready_again"}, 32'(cmd_ready), 32'd1);
    endtask

    // Directed test sequence.
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 32'd0;
        cmd_wdata = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        checkOutput("rst_addr", addr, 32'd0);
        checkOutput("rst_wr", 32'(wr), 32'd0);
        checkOutput("rst_wrdata", wrdata, 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Reset in the middle of a read discards it.
        applyStimulus(1'b0, 32'd5, 32'd0, "midrst");
        checkOutput("midrst_addr_driven", addr, 32'd5);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("midrst_addr", addr, 32'd0);
            checkOutput("midrst_wr", 32'(wr), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Write then read back.
        writeWord(32'd3, 32'h12345678, "wr3");
        readWord(32'd3, 32'h12345678, 1'b0, 0, "rd3");

        // Response backpressure.
        readWord(32'd3, 32'h12345678, 1'b0, 5, "bp3");

        // Back-to-back writes with cmd_valid held high.
        cmd_wr    = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd_addr  = 32'(i);
            cmd_wdata = 32'(i) * 32'h11;
            checkOutput("b2b_ready", 32'(cmd_ready), 32'd1);
            tick();
            checkOutput("b2b_wr", 32'(wr), 32'd1);
            checkOutput("b2b_addr", addr, 32'(i));
            checkOutput("b2b_wrdata", wrdata, 32'(i) * 32'h11);
            checkOutput("b2b_busy", 32'(cmd_ready), 32'd0);
            if (i == 15) cmd_valid = 1'b0;
            tick();
            checkOutput("b2b_wr_lo", 32'(wr), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            readWord(32'(i), 32'(i) * 32'h11, 1'b0, 0, "b2b_rd");
        end

        // Overwrite the same word twice.
        writeWord(32'd0, 32'hAAAA0000, "ow1");
        writeWord(32'd0, 32'h5555FFFF, "ow2");
        readWord(32'd0, 32'h5555FFFF, 1'b0, 0, "ow_rd");

`ifdef MEM_BUS_ADDR_CHECK_EN
        // Out-of-range commands never reach the bus.
        applyStimulus(1'b1, 32'd16, 32'hFFFFFFFF, "oor_wr");
        checkOutput("oor_wr_strobe", 32'(wr), 32'd0);
        checkOutput("oor_wr_addr", addr, 32'd0);
        checkOutput("oor_wr_wrdata", wrdata, 32'h5555FFFF);
        checkOutput("oor_wr_busy", 32'(cmd_ready), 32'd0);
        tick();
        checkOutput("oor_wr_strobe2", 32'(wr), 32'd0);
        checkOutput("oor_wr_ready", 32'(cmd_ready), 32'd1);
        readWord(32'd16, 32'hDEADBEEF, 1'b1, 0, "oor_rd");
        readWord(32'd15, 32'h000000FF, 1'b0, 0, "inr_rd15");
`else
        // Without the check the full address is passed through.
        writeWord(32'h100000F2, 32'hCAFEF00D, "wide_wr");
        readWord(32'd15, 32'h000000FF, 1'b0, 0, "rd15");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_bus_initiator.md
Name: mem_bus_initiator

Overview:
- RTL initiator for the single-cycle addr/wr/wrdata/rddata memory bus; it replaces the software-driven CPU as the bus master.
- Accepts read/write commands on a valid/ready command port and drives the bus with the fixed memory timing.
- Captures read data and returns it on a valid/ready response port.
- Sits between a command source (sequencer, DMA, test driver) and the registered 16-word memory.

Parameters:
- AW, 32, bus/command address width.
- DW, 32, data width.
- DEPTH, 16, number of memory words; used only by the optional address check.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when valid&ready.
- cmd_wr  input  1  1=write, 0=read.
- cmd_addr  input  AW  command address.
- cmd_wdata  input  DW  write data.
- rsp_valid  output  1  read response present.
- rsp_ready  input  1  response consumed when valid&ready.
- rsp_rdata  output  DW  read data.
- rsp_err  output  1  response error flag; constant 0 without ADDR_CHECK_EN.
- addr  output  AW  bus address, registered.
- wrdata  output  DW  bus write data, registered.
- wr  output  1  bus write strobe, registered.
- rddata  input  DW  bus read data; memory registers it one cycle after sampling addr.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; addr=0, wrdata=0, wr=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - In-flight read is discarded, with no response.
  - A write already sampled by memory stands.
- States: IDLE, WRITE, RD_ADDR, RD_DATA, RSP.
- cmd_ready=1 only in IDLE. No back-to-back accept; max one command per 2 cycles.
- IDLE, write accepted at edge N:
  - addr<=cmd_addr, wrdata<=cmd_wdata, wr<=1; go to WRITE.
- WRITE:
  - Memory samples the write at N+1.
  - At N+1: wr<=0, go to IDLE. wr is high for exactly one cycle.
  - Writes produce no response.
- IDLE, read accepted at edge N:
  - addr<=cmd_addr, wr<=0; go to RD_ADDR.
- RD_ADDR: memory registers rddata at N+1; go to RD_DATA.
- RD_DATA: at N+2, rsp_rdata<=rddata, rsp_valid<=1, go to RSP. Accept-to-rsp_valid latency is 2 cycles.
- RSP:
  - rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid<=0, go to IDLE.
  - A new command cannot be accepted before the next cycle.
- Bus idle rule:
  - wr=0 whenever state is not WRITE.
  - addr/wrdata hold their last values; background memory reads are harmless.
- cmd_valid while not ready: the source must hold the command stable. The block ignores it until IDLE.
- Address width: addr is passed through unchanged (no truncation) unless the check below is enabled.

Optional Feature:
- Macro: MEM_BUS_ADDR_CHECK_EN.
- Defined:
  - A command with cmd_addr >= DEPTH is accepted but never driven onto the bus; addr, wr and wrdata are unchanged.
  - Out-of-range write: dropped, 1 cycle in WRITE with wr=0.
  - Out-of-range read: same 2-cycle latency, then rsp_rdata=ERR_DATA (32'hDEADBEEF) and rsp_err=1.
- Undefined: no check; rsp_err tied 0.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state enum typedef mem_bus_state_e;
  - ERR_DATA constant;
  - DEFAULT_DEPTH=16;
  - read latency constant RD_LAT=2.
- No sub-module is natural; single module containing FSM plus registered outputs.

Test Plan:
- Reset: rst_n=0 for 3 cycles mid-read -> rsp_valid never rises; addr=0, wr=0; cmd_ready=1 one cycle after release.
- Write then read: write addr 3 data 0x12345678, then read addr 3 with rsp_ready=1 -> wr high exactly 1 cycle; rsp_valid 2 cycles after read accept; rsp_rdata=0x12345678.
- Backpressure: read addr 3, rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held stable; cmd_ready=0 throughout; cmd_ready=1 the cycle after handshake.
- Back-to-back writes: 16 writes, data=addr*0x11, cmd_valid held high, then 16 reads -> accept every 2nd cycle; all 16 read values correct.
- Overwrite: write addr 0 0xAAAA0000, then 0x5555FFFF, then read -> 0x5555FFFF.
- Address check (MEM_BUS_ADDR_CHECK_EN defined): write addr 16 0xFFFFFFFF, then read addr 16 -> wr stays 0; rsp_rdata=0xDEADBEEF, rsp_err=1. Read addr 15 -> rsp_err=0.
